gcd_lcm_coproc: RTL and testbench
=================================

Name: gcd_lcm_coproc

Overview:
- Memory-mapped GCD/LCM coprocessor: the responder on the core's data-memory bus (MemWrite, address, WriteData in; ReadData out).
- Stores set operands and start the operation; loads poll status and fetch results.
- Sits beside data memory. Top level ORs its ReadData with the memory's ReadData, so this block drives 0 when not addressed.
- Multi-cycle: subtractive GCD, then restoring divide, then multiply, giving LCM = (A/GCD)*B.

Parameters:
- BASE_ADDR, 32'h0000_0100, base of the 32-byte register window; bits [4:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  store strobe from the core.
- Addr  in  32  byte address (core ALUResult).
- WriteData  in  32  store data.
- ReadData  out  32  combinational load data; 0 when not selected.
- Busy  out  1  high while a computation is in progress.

Behaviour:
- Select: sel = (Addr[31:5] == BASE_ADDR[31:5]). Offsets use Addr[4:2]; Addr[1:0] ignored. Word access only.
- Register map (offset, access):
  - 0x00 OPA, rw.
  - 0x04 OPB, rw.
  - 0x08 CTRL, wo. Writing with bit0=1 is a start; reads return 0.
  - 0x0C STATUS, ro. bit0 busy, bit1 done, bit2 err (zero operand), bit3 ovf (LCM > 32 bits); other bits 0.
  - 0x10 GCD, ro.
  - 0x14 LCM, ro.
  - 0x18/0x1C reserved: read 0, writes ignored.
- Writes take effect on the rising clk edge when MemWrite & sel. Writes to ro/reserved offsets are ignored.
- ReadData is purely combinational from Addr and current registers (single-cycle core, zero read latency).
- Reset: all registers 0, state IDLE, ReadData 0, Busy 0.
- FSM states: IDLE, SUB, DIV, MUL.
- IDLE, start write:
  - Latch a=OPA, b=OPB; clear done, err, ovf.
  - If a==0 or b==0: GCD=0, LCM=0, err=1, done=1; stay IDLE.
  - Else: x=a, y=b, go SUB.
- SUB, one step per edge:
  - x==y: gcd_r=x, load divider (dividend a, divisor x), cnt=0, go DIV.
  - x>y: x=x-y.
  - else: y=y-x.
- DIV: one restoring-division iteration per edge, exactly 32 edges; quotient q = a/gcd (remainder is always 0). Then go MUL.
- MUL, one edge:
  - p = q*b computed as a 64-bit product.
  - LCM = p[31:0]; ovf = |p[63:32]; GCD = gcd_r; done=1; go IDLE.
- Busy = (state != IDLE); STATUS.bit0 equals Busy.
- Latency: busy cycles = N_sub + 32 + 1, where N_sub = SUB edges including the equality edge.
- Start write while busy: ignored, the running op is unaffected.
- OPA/OPB writes while busy: registers update; the running op uses latched a/b.
- GCD/LCM registers hold previous results until the MUL edge. Reads during busy return the old values.
- Simultaneous start and OPA write cannot occur (one store per cycle). Start always uses OPA/OPB values as of before that edge.
- No timeout: worst-case SUB length is ~max(a,b) cycles; software polls STATUS.
- Reset asserted mid-operation: immediate return to IDLE, all state cleared, no partial result visible.

Test Plan:
- Reset, then read each offset 0x00–0x1C, plus an unselected address 0x0000_0200 -> all read 0; Busy=0.
- OPA=12, OPB=18, start -> Busy high exactly 36 cycles (3 SUB + 32 DIV + 1 MUL) -> STATUS=0x2, GCD=6, LCM=36.
- OPA=0x0001_0000, OPB=0x0001_0001, start -> GCD=1, LCM=0x0001_0000 (low word of 0x1_0001_0000), STATUS=0xA (ovf).
- OPA=0, OPB=7, start -> next cycle Busy=0, STATUS=0x6, GCD=0, LCM=0. Then OPA=7, OPB=7 -> 1 SUB cycle, GCD=7, LCM=7, err cleared.
- Start with 21/14. While busy: write OPA=100, issue a second start, read GCD -> old GCD returned, second start ignored, final GCD=7, LCM=42. Then a start uses OPA=100.
- Start with 12/18; assert reset 10 cycles in -> Busy=0 immediately, all registers 0. New op 9/6 after reset -> GCD=3, LCM=18.

Source files
------------

// File: rtl/gcd_lcm_coproc.sv
// rtl/gcd_lcm_coproc.sv - memory-mapped GCD/LCM coprocessor on the core data bus
module gcd_lcm_coproc #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DIV  = 2'd2,
        MUL  = 2'd3
    } state_t;

    localparam logic [2:0] OFF_OPA    = 3'd0;
    localparam logic [2:0] OFF_OPB    = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_GCD    = 3'd4;
    localparam logic [2:0] OFF_LCM    = 3'd5;

    state_t      state, state_nx;

    logic [31:0] opa, opb;
    logic [31:0] gcd_reg, lcm_reg;
    logic        done, err, ovf;

    logic [31:0] a_l, b_l;
    logic [31:0] x, y;
    logic [31:0] gcd_r;
    logic [31:0] rem, quo;
    logic [4:0]  cnt;

    logic        sel;
    logic [2:0]  off;
    logic        we;
    logic        start;
    logic        zero_op;
    logic [1:0]  unused_addr;

    logic [32:0] div_trial;
    logic        div_ge;
    logic [32:0] div_diff;
    logic [31:0] rem_nx, quo_nx;
    logic [63:0] prod;

    assign sel         = (Addr[31:5] == BASE_ADDR[31:5]);
    assign off         = Addr[4:2];
    assign unused_addr = Addr[1:0];
    assign we          = MemWrite & sel;
    assign start       = we && (off == OFF_CTRL) && WriteData[0];
    assign zero_op     = (opa == 32'd0) || (opb == 32'd0);
    assign Busy        = (state != IDLE);

    // Restoring division: shift the next dividend bit into the partial remainder.
    // The remainder stays below the divisor, so the difference always fits in 32 bits.
    assign div_trial = {rem, quo[31]};
    assign div_ge    = (div_trial >= {1'b0, gcd_r});
    assign div_diff  = div_trial - {1'b0, gcd_r};
    assign rem_nx    = div_ge ? div_diff[31:0] : div_trial[31:0];
    assign quo_nx    = {quo[30:0], div_ge};

    assign prod = {32'd0, quo} * {32'd0, b_l};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !zero_op) state_nx = SUB;
            SUB:  if (x == y) state_nx = DIV;
            DIV:  if (cnt == 5'd31) state_nx = MUL;
            MUL:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa     <= '0;
            opb     <= '0;
            gcd_reg <= '0;
            lcm_reg <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;
            a_l     <= '0;
            b_l     <= '0;
            x       <= '0;
            y       <= '0;
            gcd_r   <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
        end else begin
            // Operand registers stay writable while busy; the running op uses a_l/b_l.
            if (we && off == OFF_OPA) opa <= WriteData;
            if (we && off == OFF_OPB) opb <= WriteData;

            case (state)
                IDLE: begin
                    if (start) begin
                        a_l  <= opa;
                        b_l  <= opb;
                        done <= 1'b0;
                        err  <= 1'b0;
                        ovf  <= 1'b0;
                        if (zero_op) begin
                            gcd_reg <= '0;
                            lcm_reg <= '0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            x <= opa;
                            y <= opb;
                        end
                    end
                end
                SUB: begin
                    if (x == y) begin
                        gcd_r <= x;
                        rem   <= '0;
                        quo   <= a_l;
                        cnt   <= '0;
                    end else if (x > y) begin
                        x <= x - y;
                    end else begin
                        y <= y - x;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 5'd1;
                end
                MUL: begin
                    lcm_reg <= prod[31:0];
                    ovf     <= |prod[63:32];
                    gcd_reg <= gcd_r;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (off)
                OFF_OPA:    ReadData = opa;
                OFF_OPB:    ReadData = opb;
                OFF_STATUS: ReadData = {28'd0, ovf, err, done, Busy};
                OFF_GCD:    ReadData = gcd_reg;
                OFF_LCM:    ReadData = lcm_reg;
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// tb/tb_gcd_lcm_coproc.sv - randomized self-checking bench for gcd_lcm_coproc
module tb_gcd_lcm_coproc;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] last_gcd = 0;
    logic [31:0] last_lcm = 0;

    gcd_lcm_coproc #(.BASE_ADDR(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Busy(Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        Addr      = addr;
        WriteData = data;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        Addr = addr;
        #1;
        data = ReadData;
    endtask

    function automatic logic [31:0] ref_gcd(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive GCD step count equals the sum of Euclidean quotients.
    function automatic int ref_nsub(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, t;
        int s;
        a = a_in;
        b = b_in;
        s = 0;
        while (b != 0) begin
            s += int'(a / b);
            t = a % b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    task automatic start_and_check(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0]     g, rd;
        longint unsigned p;
        int              n, s;
        logic [31:0]     exp_status, exp_gcd, exp_lcm;

        if (a == 0 || b == 0) begin
            n = 0;
            exp_gcd = 0;
            exp_lcm = 0;
            exp_status = 32'h6;
        end else begin
            g = ref_gcd(a, b);
            p = longint'(a / g) * longint'(b);
            n = ref_nsub(a, b) + 33;
            exp_gcd = g;
            exp_lcm = p[31:0];
            exp_status = (p[63:32] != 0) ? 32'hA : 32'h2;
        end

        bus_write(BASE + 32'h08, 32'h1);
        s = cyc;
        while (Busy === 1'b1 && (cyc - s) < n + 20) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_busy_cycles"}, 32'(cyc - s), 32'(n));
        bus_read(BASE + 32'h0C, rd);
        check({tag, "_status"}, rd, exp_status);
        bus_read(BASE + 32'h10, rd);
        check({tag, "_gcd"}, rd, exp_gcd);
        bus_read(BASE + 32'h14, rd);
        check({tag, "_lcm"}, rd, exp_lcm);
        last_gcd = exp_gcd;
        last_lcm = exp_lcm;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        bus_write(BASE + 32'h00, a);
        bus_write(BASE + 32'h04, b);
        start_and_check(a, b, tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] ra, rb;
        int s;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus_read(BASE + 32'(i * 4), rd);
            check($sformatf("reset_off%0h", i * 4), rd, 32'h0);
        end
        bus_read(32'h0000_0200, rd);
        check("reset_unsel", rd, 32'h0);
        check("reset_busy", 32'(Busy), 32'h0);

        run_op(32'd12, 32'd18, "op12_18");

        bus_write(BASE + 32'h10, 32'hDEAD_BEEF);
        bus_write(BASE + 32'h18, 32'h5);
        bus_write(32'h0000_0200, 32'h77);
        bus_read(BASE + 32'h10, rd);
        check("ro_write_ignored", rd, 32'd6);
        bus_read(BASE + 32'h18, rd);
        check("reserved_reads0", rd, 32'h0);
        bus_read(BASE + 32'h00, rd);
        check("unsel_write_ignored", rd, 32'd12);
        bus_read(BASE + 32'h08, rd);
        check("ctrl_reads0", rd, 32'h0);
        bus_read(32'h0000_0200, rd);
        check("unsel_reads0", rd, 32'h0);

        run_op(32'h0001_0000, 32'h0001_0001, "ovf");
        run_op(32'd0, 32'd7, "zero_a");
        run_op(32'd7, 32'd7, "eq7");

        // Writes and a second start while busy
        bus_write(BASE + 32'h00, 32'd21);
        bus_write(BASE + 32'h04, 32'd14);
        bus_write(BASE + 32'h08, 32'h1);
        s = cyc;
        bus_write(BASE + 32'h00, 32'd100);
        bus_write(BASE + 32'h08, 32'h1);
        bus_read(BASE + 32'h10, rd);
        check("busy_old_gcd", rd, last_gcd);
        bus_read(BASE + 32'h0C, rd);
        check("busy_status", rd, 32'h1);
        bus_read(BASE + 32'h00, rd);
        check("busy_opa_write", rd, 32'd100);
        while (Busy === 1'b1 && (cyc - s) < 80) begin
            @(posedge clk);
            #1;
        end
        check("restart_ignored_cycles", 32'(cyc - s), 32'(ref_nsub(21, 14) + 33));
        bus_read(BASE + 32'h10, rd);
        check("busy_final_gcd", rd, 32'd7);
        bus_read(BASE + 32'h14, rd);
        check("busy_final_lcm", rd, 32'd42);
        start_and_check(32'd100, 32'd14, "after_busy");

        // Reset in the middle of an operation
        bus_write(BASE + 32'h00, 32'd12);
        bus_write(BASE + 32'h04, 32'd18);
        bus_write(BASE + 32'h08, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_busy", 32'(Busy), 32'h0);
        for (int i = 0; i < 6; i++) begin
            bus_read(BASE + 32'(i * 4), rd);
            check($sformatf("midreset_off%0h", i * 4), rd, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd9, 32'd6, "post_reset");

        for (int i = 0; i < 10; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 120));
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 120));
            run_op(ra, rb, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
